mem_arbiter: RTL
================

# mem_arbiter

Shares the single 128-bit main-memory port between the instruction cache and the data cache. Each cache keeps its existing memory-side handshake unchanged and sees a private memory port. The arbiter grants one requester at a time using a registered grant. It records the owner of every accepted read in an in-order owner FIFO and steers each `mem_resp_valid` beat back to the cache that issued it. It sits between the two cache instances and the memory model/DRAM controller at the top of the CPU memory hierarchy.

## Interface
Parameters:
- `OUTSTANDING`, 4: depth of the read-owner FIFO (maximum number of in-flight reads); power of two, ≥2.
- `ADDR_BITS`, 28: line-beat address width (`CPU_ADDR_BITS-2-ceilLog2(MEM_DATA_BITS/CPU_INST_BITS)`).

Ports (the `ic_*` group shown; the `dc_*` group is identical):
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `ic_mem_req_valid`  in  1  icache request valid.
- `ic_mem_req_ready`  out  1  icache request accepted this cycle if valid.
- `ic_mem_req_addr`  in  ADDR_BITS  request address.
- `ic_mem_req_rw`  in  1  1 = write, 0 = read.
- `ic_mem_req_data_valid`  in  1  write data valid; asserted together with req_valid for writes.
- `ic_mem_req_data_ready`  out  1  write data accepted.
- `ic_mem_req_data_bits`  in  `MEM_DATA_BITS`  write data.
- `ic_mem_req_data_mask`  in  `MEM_DATA_BITS/8`  byte mask.
- `ic_mem_resp_valid`  out  1  read beat for icache.
- `ic_mem_resp_data`  out  `MEM_DATA_BITS`  read data (broadcast to both requesters).
- `dc_*`  same set as `ic_*`, for the data cache.
- `mem_req_valid`, `mem_req_addr`, `mem_req_rw`, `mem_req_data_valid`, `mem_req_data_bits`, `mem_req_data_mask`  out  as above  downstream memory request.
- `mem_req_ready`, `mem_req_data_ready`  in  1  downstream ready signals.
- `mem_resp_valid`  in  1  downstream read beat.
- `mem_resp_data`  in  `MEM_DATA_BITS`  downstream read data.
- `arb_err`  out  1  sticky flag: response arrived with the owner FIFO empty.

## Operation
- FSM has two states, `GNT_IC` and `GNT_DC`, held in a register. Reset state is `GNT_DC`.
- Readiness to each requester depends only on registered state and downstream ready signals, never on that requester's own valid. The caches test ready before raising valid, so this rule prevents combinational loops.
- `x_mem_req_ready` = granted(x) & `mem_req_ready` & (`x_mem_req_rw` ? `mem_req_data_ready` : !fifo_full).
- `x_mem_req_data_ready` = granted(x) & `mem_req_ready` & `mem_req_data_ready`.
- Downstream request fields are muxed from the granted requester. `mem_req_valid` equals granted valid; `mem_req_data_valid` equals granted data_valid.
- A read is accepted when valid & ready. On acceptance, push the owner ID (0 = ic, 1 = dc) into the owner FIFO.
- A write is accepted when valid & data_valid & ready. Writes push nothing.
- On `mem_resp_valid`, pop the FIFO head and pulse `resp_valid` only for that owner. `resp_data` = `mem_resp_data` to both requesters.
- If FIFO is empty on `mem_resp_valid`: no resp_valid is pulsed, the beat is dropped, and `arb_err` is set until reset.
- Push and pop in the same cycle are legal at any occupancy below full. When full, no push can occur because read ready is low.
- Grant switch, without RR: the grant moves to DC whenever `dc_mem_req_valid` is high and IC did not complete a handshake this cycle. It moves to IC when DC is idle and IC is valid.
- Reset mid-burst: FIFO is cleared and grant returns to `GNT_DC`. Late responses set `arb_err`; the memory side must be reset together with the arbiter.

## Timing
- Request path is combinational: zero added latency when the requester already holds the grant.
- A switch to a waiting requester costs exactly 1 cycle: the grant register updates at the edge after the decision.
- Response routing is combinational from `mem_resp_valid`, so the response path adds zero cycles.
- Reset values: all ready/valid outputs 0 while `reset_n`=0, `arb_err`=0, FIFO empty, pointers 0.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. After any accepted handshake, if the other requester is valid, the grant passes to it next cycle. If the granted requester is idle and the other is valid, the grant switches.
- Not defined: fixed priority with DC over IC, as described under Operation.

## Structure
- Add owner IDs `MEM_ARB_OWNER_IC`=1'b0 and `MEM_ARB_OWNER_DC`=1'b1, and the state encodings, to `const.vh`.
- One sub-module, `owner_fifo`: synchronous-write, show-ahead FIFO with width 1 and depth `OUTSTANDING`. It has async active-low clear and full/empty flags, and its pointers are one bit wider than the address for full detection.
- State and grant registers use the flop style with async active-low reset.

## Test plan
- After reset, IC read to addr 0x10 with memory always ready → accepted 1 cycle after grant switch; response beat 0xAAAA… → `ic_mem_resp_valid`=1 and `dc_mem_resp_valid`=0.
- IC and DC both issue reads continuously, responses in order with 3-cycle latency → response owners match grant order exactly; no beat is lost or duplicated.
- DC write (mask 0x000F, data 0x1234 in word 0) while `mem_req_data_ready`=0 for 5 cycles → no accept and no FIFO push; accepted on the first cycle data_ready=1.
- Issue `OUTSTANDING` reads with no response → read ready drops to 0. A write from the same requester is still accepted, and a single response re-enables reads.
- `mem_resp_valid` pulse with FIFO empty → `arb_err`=1 and stays 1; both resp_valids stay 0.
- Both requesters valid every cycle: with `MEM_ARB_ROUND_ROBIN_EN` the grants alternate IC/DC; without it DC takes every grant and IC starves.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the memory data width, the owner IDs recorded per in-flight read
// and the grant state encoding used by mem_arbiter.
package mem_arbiter_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

  // Owner ID stored in the read-owner FIFO for each accepted read.
  localparam logic MEM_ARB_OWNER_IC = 1'b0;
  localparam logic MEM_ARB_OWNER_DC = 1'b1;

  // Grant state; the encoding matches the owner IDs so the state doubles
  // as the owner of a read accepted in that state.
  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_owner_fifo.sv
// Show-ahead FIFO of 1-bit read owners, one entry per in-flight read.
// Latency: push visible at dout_o one cycle later; pop is combinational.
// Backpressure: full_o must gate the producer; push while full is ignored.
//
// Ports: clk, rst_n (async active-low clear), push_i/din_i write side,
// pop_i/dout_o read side (dout_o is the current head), full_o, empty_o.
module mem_arbiter_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry an extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bit means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit memory port between icache (ic_*) and dcache (dc_*).
// Latency: request and response paths are combinational; a grant switch costs 1 cycle.
// Backpressure: ready depends only on grant, downstream ready and owner-FIFO fullness.
//
// Ports: clk, reset_n (async active-low); per-cache request/response groups
// ic_mem_* and dc_mem_*; downstream mem_req_* / mem_resp_*; arb_err is a
// sticky flag for a response beat arriving with no read outstanding.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise DC has fixed priority over IC.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_BITS   = 28
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // icache port
  input  logic                     ic_mem_req_valid,
  output logic                     ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]     ic_mem_req_addr,
  input  logic                     ic_mem_req_rw,
  input  logic                     ic_mem_req_data_valid,
  output logic                     ic_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] ic_mem_req_data_mask,
  output logic                     ic_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_mem_resp_data,
  // dcache port
  input  logic                     dc_mem_req_valid,
  output logic                     dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]     dc_mem_req_addr,
  input  logic                     dc_mem_req_rw,
  input  logic                     dc_mem_req_data_valid,
  output logic                     dc_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_mem_req_data_bits,
  input  logic [MEM_MASK_BITS-1:0] dc_mem_req_data_mask,
  output logic                     dc_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_mem_resp_data,
  // downstream memory
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_BITS-1:0]     mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0] mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
  output logic                     arb_err
);

  gnt_e state_q, state_d;
  logic arb_err_q, arb_err_d;
  logic ic_gnt, dc_gnt;
  logic ic_rd_acc, ic_wr_acc, ic_hs;
  logic dc_rd_acc, dc_wr_acc, dc_hs;
  logic push, push_owner, pop;
  logic fifo_full, fifo_empty, fifo_head;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= GNT_DC;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arb_err_q <= arb_err_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Hand over after a completed handshake, or when the holder is idle.
    if (state_q == GNT_IC) begin
      if (dc_mem_req_valid && (ic_hs || !ic_mem_req_valid)) state_d = GNT_DC;
    end else begin
      if (ic_mem_req_valid && (dc_hs || !dc_mem_req_valid)) state_d = GNT_IC;
    end
`else
    // DC wins whenever it asks, unless IC is completing a handshake right now.
    if (dc_mem_req_valid && !ic_hs)                    state_d = GNT_DC;
    else if (!dc_mem_req_valid && ic_mem_req_valid)    state_d = GNT_IC;
`endif
    arb_err_d = arb_err_q || (mem_resp_valid && fifo_empty);
  end

  // ---------------- output logic ----------------
  always_comb begin
    // reset_n gating keeps every ready/valid low while reset is asserted.
    ic_gnt = reset_n && (state_q == GNT_IC);
    dc_gnt = reset_n && (state_q == GNT_DC);

    // Reads also need a free owner slot; writes need the data channel.
    ic_mem_req_ready = ic_gnt && mem_req_ready &&
                       (ic_mem_req_rw ? mem_req_data_ready : !fifo_full);
    dc_mem_req_ready = dc_gnt && mem_req_ready &&
                       (dc_mem_req_rw ? mem_req_data_ready : !fifo_full);
    ic_mem_req_data_ready = ic_gnt && mem_req_ready && mem_req_data_ready;
    dc_mem_req_data_ready = dc_gnt && mem_req_ready && mem_req_data_ready;

    mem_req_valid      = (ic_gnt && ic_mem_req_valid) || (dc_gnt && dc_mem_req_valid);
    mem_req_data_valid = (ic_gnt && ic_mem_req_data_valid) ||
                         (dc_gnt && dc_mem_req_data_valid);
    if (state_q == GNT_IC) begin
      mem_req_addr      = ic_mem_req_addr;
      mem_req_rw        = ic_mem_req_rw;
      mem_req_data_bits = ic_mem_req_data_bits;
      mem_req_data_mask = ic_mem_req_data_mask;
    end else begin
      mem_req_addr      = dc_mem_req_addr;
      mem_req_rw        = dc_mem_req_rw;
      mem_req_data_bits = dc_mem_req_data_bits;
      mem_req_data_mask = dc_mem_req_data_mask;
    end

    // A beat is steered only to the owner at the FIFO head.
    ic_mem_resp_valid = reset_n && pop && (fifo_head == MEM_ARB_OWNER_IC);
    dc_mem_resp_valid = reset_n && pop && (fifo_head == MEM_ARB_OWNER_DC);
    ic_mem_resp_data  = mem_resp_data;
    dc_mem_resp_data  = mem_resp_data;
    arb_err           = arb_err_q;
  end

  // ---------------- handshakes and owner tracking ----------------
  assign ic_rd_acc = ic_mem_req_valid && ic_mem_req_ready && !ic_mem_req_rw;
  assign ic_wr_acc = ic_mem_req_valid && ic_mem_req_ready && ic_mem_req_rw &&
                     ic_mem_req_data_valid;
  assign ic_hs     = ic_rd_acc || ic_wr_acc;
  assign dc_rd_acc = dc_mem_req_valid && dc_mem_req_ready && !dc_mem_req_rw;
  assign dc_wr_acc = dc_mem_req_valid && dc_mem_req_ready && dc_mem_req_rw &&
                     dc_mem_req_data_valid;
  assign dc_hs     = dc_rd_acc || dc_wr_acc;

  assign push       = ic_rd_acc || dc_rd_acc;
  assign push_owner = dc_rd_acc ? MEM_ARB_OWNER_DC : MEM_ARB_OWNER_IC;
  assign pop        = mem_resp_valid && !fifo_empty;

  mem_arbiter_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .din_i   (push_owner),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
